// File: rtl/tlc_pkg.sv
// Package: tlc_pkg
// Shared definitions for the demand-driven intersection phase arbiter.
//  - state codes for the ALLRED -> GREEN -> YELLOW -> ALLRED sequence
//  - phase (approach) codes: R0 road, R1 road, C crosswalk
//  - phase arithmetic helpers (modulo-3 increment / add)
//  - lamp decode: state + phase -> 9-bit {R0G,R0Y,R0R,R1G,R1Y,R1R,CG,CY,CR}
package tlc_pkg;

  localparam logic [1:0] ST_ALLRED = 2'd0;
  localparam logic [1:0] ST_GREEN  = 2'd1;
  localparam logic [1:0] ST_YELLOW = 2'd2;

  localparam logic [1:0] PH_R0 = 2'd0;
  localparam logic [1:0] PH_R1 = 2'd1;
  localparam logic [1:0] PH_C  = 2'd2;

  localparam int NUM_APPR = 3;

  // Lamp vector with every approach showing red.
  localparam logic [8:0] LAMPS_ALL_RED = 9'b001_001_001;

  typedef enum logic [1:0] {
    S_ALLRED = ST_ALLRED,
    S_GREEN  = ST_GREEN,
    S_YELLOW = ST_YELLOW
  } tlc_state_e;

  // Next approach in the fixed R0 -> R1 -> C -> R0 rotation.
  // The unused code 3 folds onto R0 so the rotation can never stick on it.
  function automatic logic [1:0] phase_inc(input logic [1:0] p);
    logic [1:0] r;
    case (p)
      PH_R0:   r = PH_R1;
      PH_R1:   r = PH_C;
      default: r = PH_R0;
    endcase
    return r;
  endfunction

  // Advance a phase by n steps (n in 0..3) around the rotation.
  function automatic logic [1:0] phase_add(input logic [1:0] p, input int n);
    logic [1:0] r;
    r = p;
    for (int i = 0; i < 3; i++) begin
      if (i < n) r = phase_inc(r);
    end
    return r;
  endfunction

  // Lamp decode. Only the owner approach can be non-red, and only in
  // GREEN or YELLOW; ALLRED shows red everywhere regardless of phase.
  function automatic logic [8:0] lamp_vec(input tlc_state_e st, input logic [1:0] ph);
    logic [8:0] v;
    logic [2:0] active;
    v      = LAMPS_ALL_RED;
    active = (st == S_GREEN) ? 3'b100 : 3'b010;
    if (st != S_ALLRED) begin
      case (ph)
        PH_R0:   v[8:6] = active;
        PH_R1:   v[5:3] = active;
        default: v[2:0] = active;
      endcase
    end
    return v;
  endfunction

endpackage

// File: rtl/tlc_rr_pick.sv
// Module: tlc_rr_pick
// Combinational 3-way round-robin picker. Starting just after the last
// owner, searches last+1, last+2, last (mod 3) and returns the first
// approach whose pending bit is set.
// Ports:
//  pend   in  3  pending requests, [0]=R0 [1]=R1 [2]=C
//  last   in  2  phase that owned the previous green
//  next   out 2  chosen phase (PH_R0 when nothing is pending)
//  found  out 1  at least one pending bit was set
module tlc_rr_pick
  import tlc_pkg::*;
(
  input  logic [2:0] pend,
  input  logic [1:0] last,
  output logic [1:0] next,
  output logic       found
);

  // Candidate k is the (k+1)-th phase after the last owner; candidate 2
  // wraps back to the last owner itself, so it is served last.
  logic [1:0] cand [NUM_APPR];
  logic [2:0] hit;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_APPR; gi++) begin : g_cand
      assign cand[gi] = phase_add(last, gi + 1);
      assign hit[gi]  = pend[cand[gi]];
    end
  endgenerate

  always_comb begin
    found = |hit;
    next  = PH_R0;
    if (hit[0]) begin
      next = cand[0];
    end else if (hit[1]) begin
      next = cand[1];
    end else if (hit[2]) begin
      next = cand[2];
    end
  end

endmodule

// File: rtl/tlc_phase_arbiter.sv
// Module: tlc_phase_arbiter
// Demand-driven phase scheduler for a two-road-plus-crosswalk intersection.
// Latches sensor/button requests, grants green round-robin, enforces
// min/max green, yellow and all-red clearance, and drives all nine lamps
// from registers.
// Ports:
//  clk                 in  1  clock, rising edge
//  reset               in  1  asynchronous active-low reset
//  req                 in  3  requests [0]=R0 sensor [1]=R1 sensor [2]=C button
//  R0G/R0Y/R0R         out 1  road 0 lamps
//  R1G/R1Y/R1R         out 1  road 1 lamps
//  CG/CY/CR            out 1  crosswalk lamps
//  pend                out 3  latched pending requests (req bit order)
//  phase               out 2  current owner 0=R0 1=R1 2=C
module tlc_phase_arbiter
  import tlc_pkg::*;
#(
  parameter int MIN_GREEN = 4,
  parameter int MAX_GREEN = 12,
  parameter int YELLOW    = 3,
  parameter int ALL_RED   = 1,
  parameter int CNT_W     = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] req,
  output logic       R0G,
  output logic       R0Y,
  output logic       R0R,
  output logic       R1G,
  output logic       R1Y,
  output logic       R1R,
  output logic       CG,
  output logic       CY,
  output logic       CR,
  output logic [2:0] pend,
  output logic [1:0] phase
);

  // Timer thresholds: the timer reads 0 on the first cycle of a state, so
  // a state lasting N cycles ends on the edge where the timer holds N-1.
  localparam logic [CNT_W-1:0] MIN_LIM = CNT_W'(MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] MAX_LIM = CNT_W'(MAX_GREEN - 1);
  localparam logic [CNT_W-1:0] Y_LIM   = CNT_W'(YELLOW - 1);
  localparam logic [CNT_W-1:0] AR_LIM  = CNT_W'(ALL_RED - 1);

  tlc_state_e       state_reg, state_next;
  logic [CNT_W-1:0] timer_reg, timer_next;
  logic [1:0]       phase_reg, phase_next;
  logic [2:0]       pend_reg, pend_next;
  logic [8:0]       lamps_reg;

  logic [2:0] owner_mask;
  logic       other_waiting;
  logic       owner_req;
  logic [1:0] pick_phase;
  logic       pick_found;

  assign owner_mask    = 3'b001 << phase_reg;
  assign other_waiting = |(pend_reg & ~owner_mask);
  assign owner_req     = |(req & owner_mask);

  tlc_rr_pick u_pick (
    .pend  (pend_reg),
    .last  (phase_reg),
    .next  (pick_phase),
    .found (pick_found)
  );

  always_comb begin
    logic [2:0] req_latch;
    logic [2:0] grant_mask;

    state_next = state_reg;
    phase_next = phase_reg;
    timer_next = timer_reg + 1'b1;

    // The owner's own request is already being served while it is green,
    // so it is dropped then; during yellow/all-red it must be remembered.
    req_latch = req;
    if (state_reg == S_GREEN) begin
      req_latch = req & ~owner_mask;
    end
    pend_next  = pend_reg | req_latch;
    grant_mask = 3'b000;

    case (state_reg)
      S_ALLRED: begin
        if (timer_reg >= AR_LIM) begin
          state_next = S_GREEN;
          // Nothing pending: park on R0, the rest phase.
          phase_next = pick_found ? pick_phase : PH_R0;
          grant_mask = 3'b001 << phase_next;
          // Grant clears after the set, so the clear wins a same-cycle race.
          pend_next  = pend_next & ~grant_mask;
        end
      end

      S_GREEN: begin
        if (other_waiting && ((timer_reg >= MIN_LIM && !owner_req) ||
                              (timer_reg >= MAX_LIM))) begin
          state_next = S_YELLOW;
        end else if (timer_reg >= MAX_LIM) begin
          // Uncontested green holds forever; keep the timer pinned so a
          // later request can max-out immediately instead of waiting.
          timer_next = MAX_LIM;
        end
      end

      S_YELLOW: begin
        if (timer_reg >= Y_LIM) begin
          state_next = S_ALLRED;
        end
      end

      default: begin
        state_next = S_ALLRED;
      end
    endcase

    if (state_next != state_reg) begin
      timer_next = '0;
    end
  end

  // Lamps are decoded from the next state so they change on the same edge
  // that enters the state, straight out of flops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= S_ALLRED;
      phase_reg <= PH_C;
      timer_reg <= '0;
      pend_reg  <= '0;
      lamps_reg <= LAMPS_ALL_RED;
    end else begin
      state_reg <= state_next;
      phase_reg <= phase_next;
      timer_reg <= timer_next;
      pend_reg  <= pend_next;
      lamps_reg <= lamp_vec(state_next, phase_next);
    end
  end

  assign {R0G, R0Y, R0R, R1G, R1Y, R1R, CG, CY, CR} = lamps_reg;
  assign pend  = pend_reg;
  assign phase = phase_reg;

endmodule

// File: tb/tb_tlc_phase_arbiter.sv
// Testbench: tb_tlc_phase_arbiter
// Directed scenarios (idle, gap-out, round-robin, max-out, async reset in
// yellow) followed by a random request run with per-cycle invariant checks.
// Outputs are sampled on the falling edge; inputs change on the falling edge.
module tb_tlc_phase_arbiter;

  localparam int MIN_GREEN = 4;
  localparam int MAX_GREEN = 12;
  localparam int YELLOW    = 3;
  localparam int ALL_RED   = 1;
  // A request raised during its own approach's yellow is searched last,
  // so it can wait for the rest of that clearance plus two full services.
  localparam int STARVE_BOUND = 2 * (MAX_GREEN + YELLOW + ALL_RED) + YELLOW + ALL_RED;

  localparam logic [8:0] AR = 9'b001_001_001;
  localparam logic [8:0] G0 = 9'b100_001_001;
  localparam logic [8:0] Y0 = 9'b010_001_001;
  localparam logic [8:0] G1 = 9'b001_100_001;
  localparam logic [8:0] Y1 = 9'b001_010_001;
  localparam logic [8:0] GC = 9'b001_001_100;
  localparam logic [8:0] YC = 9'b001_001_010;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] req;
  logic       R0G, R0Y, R0R, R1G, R1Y, R1R, CG, CY, CR;
  logic [2:0] pend;
  logic [1:0] phase;
  logic [8:0] lamps;

  int errors = 0;
  int checks = 0;

  assign lamps = {R0G, R0Y, R0R, R1G, R1Y, R1R, CG, CY, CR};

  always #5 clk = ~clk;

  tlc_phase_arbiter #(
    .MIN_GREEN (MIN_GREEN),
    .MAX_GREEN (MAX_GREEN),
    .YELLOW    (YELLOW),
    .ALL_RED   (ALL_RED),
    .CNT_W     (5)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .R0G   (R0G),
    .R0Y   (R0Y),
    .R0R   (R0R),
    .R1G   (R1G),
    .R1Y   (R1Y),
    .R1R   (R1R),
    .CG    (CG),
    .CY    (CY),
    .CR    (CR),
    .pend  (pend),
    .phase (phase)
  );

  task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic expect_lamps(input string tag, input logic [8:0] exp, input int n);
    for (int i = 0; i < n; i++) begin
      step();
      check(tag, lamps, exp);
    end
  endtask

  // Hold reset for two cycles, check the reset state, release on a falling
  // edge so the next rising edge is cycle 0.
  task automatic do_reset();
    reset = 1'b0;
    req   = 3'b000;
    step();
    step();
    check("rst_lamps", lamps, AR);
    check("rst_pend", 9'(pend), 9'd0);
    check("rst_phase", 9'(phase), 9'd2);
    reset = 1'b1;
  endtask

  initial begin
    logic [8:0] lam;
    logic [2:0] g, y, r, prev_g;
    logic       prev_y_any;
    int         y_run, ar_run, nonred;
    int         age [3];
    logic       onehot_ok;

    reset = 1'b0;
    req   = 3'b000;

    // 1: idle -> R0 green after one all-red cycle, held indefinitely
    do_reset();
    expect_lamps("s1_r0_green", G0, 50);
    check("s1_pend", 9'(pend), 9'd0);
    check("s1_phase", 9'(phase), 9'd0);

    // 2: gap-out to R1
    do_reset();
    step();                                       // n0
    check("s2_g0_n0", lamps, G0);
    step();                                       // n1
    check("s2_g0_n1", lamps, G0);
    req = 3'b010;
    step();                                       // n2
    req = 3'b000;
    check("s2_g0_n2", lamps, G0);
    check("s2_pend_set", 9'(pend), 9'b010);
    expect_lamps("s2_g0_n3", G0, 1);
    expect_lamps("s2_y0", Y0, YELLOW);
    expect_lamps("s2_allred", AR, ALL_RED);
    step();                                       // n8
    check("s2_g1", lamps, G1);
    check("s2_phase", 9'(phase), 9'd1);
    check("s2_pend_clr", 9'(pend), 9'd0);

    // 4: round-robin from R1 green with R0 and C both waiting
    req = 3'b101;
    step();                                       // n9
    req = 3'b000;
    check("s4_g1", lamps, G1);
    check("s4_pend", 9'(pend), 9'b101);
    expect_lamps("s4_g1_rest", G1, 2);
    expect_lamps("s4_y1", Y1, YELLOW);
    expect_lamps("s4_allred1", AR, ALL_RED);
    step();                                       // n16
    check("s4_gc", lamps, GC);
    check("s4_phase_c", 9'(phase), 9'd2);
    check("s4_pend_after_c", 9'(pend), 9'b001);
    expect_lamps("s4_gc_rest", GC, 3);
    expect_lamps("s4_yc", YC, YELLOW);
    expect_lamps("s4_allred2", AR, ALL_RED);
    step();                                       // n24
    check("s4_g0", lamps, G0);
    check("s4_phase_r0", 9'(phase), 9'd0);
    check("s4_pend_empty", 9'(pend), 9'd0);
    expect_lamps("s4_no_regrant", G0, 30);

    // 3: max-out with R0 sensor held
    do_reset();
    req = 3'b001;
    step();                                       // n0
    check("s3_g0_n0", lamps, G0);
    check("s3_pend_n0", 9'(pend), 9'd0);
    req = 3'b101;
    step();                                       // n1
    req = 3'b001;
    check("s3_g0_n1", lamps, G0);
    check("s3_pend_c", 9'(pend), 9'b100);
    expect_lamps("s3_g0_hold", G0, MAX_GREEN - 2);
    expect_lamps("s3_y0", Y0, YELLOW);
    expect_lamps("s3_allred", AR, ALL_RED);
    step();                                       // n16
    check("s3_gc", lamps, GC);
    check("s3_phase", 9'(phase), 9'd2);
    check("s3_pend_r0_latched", 9'(pend), 9'b001);
    req = 3'b000;

    // 5: asynchronous reset in the middle of yellow
    do_reset();
    step();                                       // n0
    check("s5_g0", lamps, G0);
    req = 3'b100;
    step();                                       // n1
    req = 3'b000;
    check("s5_pend", 9'(pend), 9'b100);
    expect_lamps("s5_g0_rest", G0, 2);
    expect_lamps("s5_y0", Y0, 1);
    check("s5_pend_in_y", 9'(pend), 9'b100);
    #2 reset = 1'b0;
    #1;
    check("s5_async_lamps", lamps, AR);
    check("s5_async_pend", 9'(pend), 9'd0);
    check("s5_async_phase", 9'(phase), 9'd2);
    step();
    reset = 1'b1;
    expect_lamps("s5_after_release", G0, 10);
    check("s5_pend_after", 9'(pend), 9'd0);

    // 6: random request stress with invariant monitor
    do_reset();
    prev_g     = 3'b000;
    prev_y_any = 1'b0;
    y_run      = 0;
    ar_run     = 1;
    for (int a = 0; a < 3; a++) age[a] = 0;
    for (int cyc = 0; cyc < 5000; cyc++) begin
      req[0] = ($urandom_range(0, 9) == 0);
      req[1] = ($urandom_range(0, 7) == 0);
      req[2] = ($urandom_range(0, 11) == 0);
      step();
      lam       = lamps;
      onehot_ok = 1'b1;
      nonred    = 0;
      for (int a = 0; a < 3; a++) begin
        g[a] = lam[8 - 3 * a];
        y[a] = lam[7 - 3 * a];
        r[a] = lam[6 - 3 * a];
        if ((int'(g[a]) + int'(y[a]) + int'(r[a])) != 1) onehot_ok = 1'b0;
        if (!r[a]) nonred++;
      end
      check("s6_onehot", 9'(onehot_ok), 9'd1);
      check("s6_nonred_le1", 9'(nonred <= 1), 9'd1);
      for (int a = 0; a < 3; a++) begin
        if (prev_g[a] && !g[a]) check("s6_green_to_yellow", 9'(y[a]), 9'd1);
      end
      if (prev_y_any && !(|y)) begin
        check("s6_yellow_len", 9'(y_run >= YELLOW), 9'd1);
        check("s6_yellow_to_allred", 9'(&r), 9'd1);
      end
      if ((|g) && !(|prev_g)) begin
        check("s6_allred_before_green", 9'(ar_run >= ALL_RED), 9'd1);
      end
      y_run  = (|y) ? y_run + 1 : 0;
      ar_run = (&r) ? ar_run + 1 : 0;
      for (int a = 0; a < 3; a++) begin
        age[a] = pend[a] ? age[a] + 1 : 0;
        check("s6_starvation", 9'(age[a] <= STARVE_BOUND), 9'd1);
      end
      prev_g     = g;
      prev_y_any = |y;
    end
    req = 3'b000;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
